// File: rtl/spi_reg_ctrl_if.sv
// SPI bus bundle between an external controller and the register target.
// The controller drives sclk/copi/ncs and the target drives cipo/cipo_oe.
interface spi_reg_ctrl_if;
   logic sclk;
   logic copi;
   logic ncs;
   logic cipo;
   logic cipo_oe;

   modport master (
      output sclk,
      output copi,
      output ncs,
      input  cipo,
      input  cipo_oe
   );

   modport slave (
      input  sclk,
      input  copi,
      input  ncs,
      output cipo,
      output cipo_oe
   );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 target that loads the five PWM control registers.
// Frames are 16 bits MSB first; writes commit only when the frame closes.
module spi_reg_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_ADDR    = 4
) (
   input  logic          clk,
   input  logic          rst,
   spi_reg_ctrl_if.slave spi,
   output logic [7:0]    en_reg_out_7_0,
   output logic [7:0]    en_reg_out_15_8,
   output logic [7:0]    en_reg_pwm_7_0,
   output logic [7:0]    en_reg_pwm_15_8,
   output logic [7:0]    pwm_duty_cycle,
   output logic          txn_done,
   output logic          txn_err
);

   localparam int         NREG  = 5;
   localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

   typedef enum logic [2:0] {
      S_WAIT_IDLE,
      S_IDLE,
      S_SHIFT,
      S_HOLD,
      S_END
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
   logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
   logic                   sclk_hist_q, sclk_hist_d;
   logic                   ncs_hist_q, ncs_hist_d;

   logic [15:0] shift_q, shift_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        short_q, short_d;
   logic [7:0]  tx_q, tx_d;
   logic        cipo_q, cipo_d;
   logic        oe_q, oe_d;
   logic [7:0]  regs_q [NREG];
   logic [7:0]  regs_d [NREG];
   logic [7:0]  rd_val;

   logic sclk_s, copi_s, ncs_s;
   logic sclk_rise, sclk_fall;
   logic ncs_rise, ncs_fall;
   logic addr_ok, frame_ok;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign copi_s = copi_sync_q[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_hist_q;
   assign sclk_fall = ~sclk_s & sclk_hist_q;
   assign ncs_rise  = ncs_s & ~ncs_hist_q;
   assign ncs_fall  = ~ncs_s & ncs_hist_q;

   // A frame is good only if it ran all 16 bits and hit a real register.
   assign addr_ok  = shift_q[14:8] <= MAX_A;
   assign frame_ok = !short_q && addr_ok;

   // Next values for the synchroniser chains and edge-history flops.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
      ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
      sclk_hist_d = sclk_s;
      ncs_hist_d  = ncs_s;
   end

   // Synchroniser flops; cleared low so WAIT_IDLE waits for a real ncs high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q <= '0;
         copi_sync_q <= '0;
         ncs_sync_q  <= '0;
         sclk_hist_q <= 1'b0;
         ncs_hist_q  <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         copi_sync_q <= copi_sync_d;
         ncs_sync_q  <= ncs_sync_d;
         sclk_hist_q <= sclk_hist_d;
         ncs_hist_q  <= ncs_hist_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_WAIT_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: frame framing by ncs, 16 captured bits move to HOLD.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_WAIT_IDLE: begin
            if (ncs_s) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (ncs_fall) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (ncs_rise) begin
               state_d = S_END;
            end else if (sclk_rise && cnt_q == 5'd15) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (ncs_rise) state_d = S_END;
         end
         S_END: begin
            state_d = S_IDLE;
         end
         default: state_d = S_WAIT_IDLE;
      endcase
   end

   // FSM outputs: one status pulse during the END cycle.
   always_comb begin
      txn_done = 1'b0;
      txn_err  = 1'b0;
      if (state_q == S_END) begin
         txn_done = frame_ok;
         txn_err  = !frame_ok;
      end
   end

   // Datapath: shift in COPI, commit in END, serialise read data on CIPO.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      short_d = short_q;
      tx_d    = tx_q;
      cipo_d  = cipo_q;
      oe_d    = oe_q;
      regs_d  = regs_q;
      rd_val  = 8'h00;
      unique case (state_q)
         S_IDLE: begin
            if (ncs_fall) begin
               short_d = 1'b0;
               if (sclk_rise) begin
                  shift_d = {15'd0, copi_s};
                  cnt_d   = 5'd1;
               end else begin
                  shift_d = '0;
                  cnt_d   = '0;
               end
            end
         end
         S_SHIFT: begin
            if (ncs_rise) begin
               short_d = 1'b1;
            end else if (sclk_rise) begin
               shift_d = {shift_q[14:0], copi_s};
               cnt_d   = cnt_q + 5'd1;
            end
         end
         S_END: begin
            if (frame_ok && shift_q[15]) begin
               for (int i = 0; i < NREG; i++) begin
                  if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
               end
            end
         end
         default: ;
      endcase
      for (int i = 0; i < NREG; i++) begin
         if (shift_d[6:0] == 7'(i) && shift_d[6:0] <= MAX_A) begin
            rd_val = regs_q[i];
         end
      end
      if (state_q == S_SHIFT && sclk_rise && !ncs_rise &&
          cnt_q == 5'd7 && !shift_d[7]) begin
         tx_d = rd_val;
         oe_d = 1'b1;
      end else if (oe_q && sclk_fall) begin
         cipo_d = tx_q[7];
         tx_d   = {tx_q[6:0], 1'b0};
      end
      if (ncs_rise) begin
         oe_d   = 1'b0;
         cipo_d = 1'b0;
         tx_d   = '0;
      end
   end

   // Datapath flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
         short_q <= 1'b0;
         tx_q    <= '0;
         cipo_q  <= 1'b0;
         oe_q    <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         short_q <= short_d;
         tx_q    <= tx_d;
         cipo_q  <= cipo_d;
         oe_q    <= oe_d;
         regs_q  <= regs_d;
      end
   end

   assign spi.cipo    = cipo_q;
   assign spi.cipo_oe = oe_q;

   assign en_reg_out_7_0  = regs_q[0];
   assign en_reg_out_15_8 = regs_q[1];
   assign en_reg_pwm_7_0  = regs_q[2];
   assign en_reg_pwm_15_8 = regs_q[3];
   assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed SPI frames against a register model.
// A per-cycle compare process checks registers, pulses and idle CIPO.
module tb_spi_reg_ctrl;

   localparam int PH = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_reg_ctrl_if spi_bus ();

   logic [7:0] r0, r1, r2, r3, r4;
   logic       txn_done, txn_err;

   spi_reg_ctrl #(
      .SYNC_STAGES(2),
      .MAX_ADDR   (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .spi            (spi_bus),
      .en_reg_out_7_0 (r0),
      .en_reg_out_15_8(r1),
      .en_reg_pwm_7_0 (r2),
      .en_reg_pwm_15_8(r3),
      .pwm_duty_cycle (r4),
      .txn_done       (txn_done),
      .txn_err        (txn_err)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] model [0:4];
   bit busy  = 1'b0;
   bit oe_dc = 1'b0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int exp_done = 0;
   int exp_err  = 0;
   logic [7:0] rd;

   function automatic void chk(input bit ok, input string name,
                               input logic [63:0] act,
                               input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t",
                  name, act, req, $time);
      end
   endfunction

   // Per-cycle compare against the model whenever outputs are settled.
   always @(negedge clk) begin
      if (!rst) begin
         if (txn_done === 1'b1) done_cnt++;
         if (txn_err === 1'b1) err_cnt++;
         if (!busy) begin
            chk({r4, r3, r2, r1, r0} ===
                {model[4], model[3], model[2], model[1], model[0]},
                "regs", {r4, r3, r2, r1, r0},
                {model[4], model[3], model[2], model[1], model[0]});
            chk(txn_done === 1'b0 && txn_err === 1'b0, "idle_pulse",
                {txn_done, txn_err}, 64'd0);
         end
         if (!oe_dc) begin
            chk(spi_bus.cipo_oe === 1'b0 && spi_bus.cipo === 1'b0,
                "cipo_idle", {spi_bus.cipo_oe, spi_bus.cipo}, 64'd0);
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sclk_edge(input logic b);
      spi_bus.copi = b;
      wait_clk(PH);
      spi_bus.sclk = 1'b1;
      wait_clk(PH);
      spi_bus.sclk = 1'b0;
   endtask

   // Runs one frame, updates the model, leaves ncs high with busy set.
   task automatic frame_body(input logic [15:0] f, input int nedges,
                             output logic [7:0] rdv);
      logic [6:0] a;
      logic [7:0] exp_rd;
      bit is_rd, ok;
      a      = f[14:8];
      is_rd  = !f[15];
      exp_rd = (a <= 7'd4) ? model[a[2:0]] : 8'h00;
      rdv    = 8'h00;
      spi_bus.ncs = 1'b0;
      wait_clk(PH);
      for (int i = 0; i < nedges; i++) begin
         spi_bus.copi = (i < 16) ? f[15-i] : 1'b0;
         if (is_rd && i == 7) oe_dc = 1'b1;
         wait_clk(PH);
         if (is_rd && i >= 8 && i < 16) begin
            chk(spi_bus.cipo_oe === 1'b1, "cipo_oe",
                {63'd0, spi_bus.cipo_oe}, 64'd1);
            chk(spi_bus.cipo === exp_rd[15-i], "cipo_bit",
                {63'd0, spi_bus.cipo}, {63'd0, exp_rd[15-i]});
            rdv = {rdv[6:0], spi_bus.cipo};
         end
         spi_bus.sclk = 1'b1;
         wait_clk(PH);
         spi_bus.sclk = 1'b0;
      end
      wait_clk(PH);
      ok = (nedges >= 16) && (a <= 7'd4);
      if (ok) exp_done++;
      else exp_err++;
      busy = 1'b1;
      if (ok && f[15]) model[a[2:0]] = f[7:0];
      spi_bus.ncs = 1'b1;
   endtask

   task automatic settle();
      wait_clk(6);
      chk(done_cnt == exp_done, "txn_done_count", 64'(done_cnt),
          64'(exp_done));
      chk(err_cnt == exp_err, "txn_err_count", 64'(err_cnt),
          64'(exp_err));
      busy  = 1'b0;
      oe_dc = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
      spi_bus.sclk = 1'b0;
      spi_bus.copi = 1'b0;
      spi_bus.ncs  = 1'b1;
      rst = 1'b1;
      wait_clk(4);
      rst = 1'b0;
      chk({r4, r3, r2, r1, r0} === 40'd0, "rst_regs",
          {r4, r3, r2, r1, r0}, 64'd0);
      chk(spi_bus.cipo === 1'b0, "rst_cipo", {63'd0, spi_bus.cipo}, 0);
      chk(spi_bus.cipo_oe === 1'b0, "rst_oe",
          {63'd0, spi_bus.cipo_oe}, 0);
      chk(txn_done === 1'b0, "rst_done", {63'd0, txn_done}, 0);
      chk(txn_err === 1'b0, "rst_err", {63'd0, txn_err}, 0);
      wait_clk(5);

      frame_body(16'h80F0, 16, rd);
      wait_clk(4);
      chk(r0 === 8'hF0, "wr0_latency", {56'd0, r0}, 64'hF0);
      settle();
      chk(done_cnt == 1, "first_done", 64'(done_cnt), 64'd1);

      frame_body(16'h8480, 16, rd);
      settle();
      frame_body(16'h0400, 16, rd);
      settle();
      chk(rd === 8'h80, "rd4_byte", {56'd0, rd}, 64'h80);
      chk(r4 === 8'h80, "rd4_keep", {56'd0, r4}, 64'h80);

      frame_body(16'h85AA, 16, rd);
      settle();
      frame_body(16'h0700, 16, rd);
      settle();
      chk(rd === 8'h00, "rd7_byte", {56'd0, rd}, 64'h00);

      frame_body(16'h8255, 10, rd);
      settle();
      chk(r2 === 8'h00, "short_keep", {56'd0, r2}, 64'h00);
      frame_body(16'h82FF, 20, rd);
      settle();
      chk(r2 === 8'hFF, "hold_wr2", {56'd0, r2}, 64'hFF);

      frame_body(16'h8301, 16, rd);
      settle();
      spi_bus.ncs = 1'b0;
      wait_clk(PH);
      for (int i = 0; i < 4; i++) sclk_edge(i == 0);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
      wait_clk(3);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) sclk_edge(1'b1);
      wait_clk(PH);
      busy = 1'b1;
      spi_bus.ncs = 1'b1;
      settle();
      chk({r4, r3, r2, r1, r0} === 40'd0, "midrst_regs",
          {r4, r3, r2, r1, r0}, 64'd0);
      frame_body(16'h8107, 16, rd);
      settle();
      chk(r1 === 8'h07, "after_rst_wr1", {56'd0, r1}, 64'h07);

      frame_body(16'h8112, 16, rd);
      wait_clk(3);
      frame_body(16'h8234, 16, rd);
      settle();
      chk(r1 === 8'h12, "b2b_r1", {56'd0, r1}, 64'h12);
      chk(r2 === 8'h34, "b2b_r2", {56'd0, r2}, 64'h34);

      wait_clk(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
